// File: rtl/id_regfile.sv
// rtl/id_regfile.sv - 32x32 decode-stage register file with write-back forwarding
`timescale 1ns/1ps
module id_regfile #(
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  IDin_Ra,
  input  logic [4:0]  IDin_Rb,
  input  logic [31:0] WRin_RegDin,
  input  logic [4:0]  WRin_Rw,
  input  logic        WRin_RegWE,
  output logic [31:0] IDout_BusA,
  output logic [31:0] IDout_BusB,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data,
  output logic [31:0] wr_count
);

  // Entry 0 has no storage; reads of address 0 fall through to zero.
  logic [31:0] entries [1:31];
  logic [31:0] stored_a;
  logic [31:0] stored_b;
  logic        commit;

  // WE gates the compare so an unknown address with WE low cannot commit.
  assign commit = WRin_RegWE && (WRin_Rw != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < 32; i++) entries[i] <= '0;
      wr_count <= '0;
    end else if (commit) begin
      for (int i = 1; i < 32; i++) begin
        if (WRin_Rw == 5'(i)) entries[i] <= WRin_RegDin;
      end
      wr_count <= wr_count + 32'd1;
    end
  end

  always_comb begin
    stored_a = '0;
    stored_b = '0;
    dbg_data = '0;
    for (int i = 1; i < 32; i++) begin
      if (IDin_Ra == 5'(i))  stored_a = entries[i];
      if (IDin_Rb == 5'(i))  stored_b = entries[i];
      if (dbg_addr == 5'(i)) dbg_data = entries[i];
    end
  end

  // Forward the in-flight write so decode sees it without a stall cycle.
  assign IDout_BusA = (BYPASS_EN && commit && (WRin_Rw == IDin_Ra)) ? WRin_RegDin : stored_a;
  assign IDout_BusB = (BYPASS_EN && commit && (WRin_Rw == IDin_Rb)) ? WRin_RegDin : stored_b;

endmodule

// File: tb/tb_id_regfile.sv
// tb/tb_id_regfile.sv - directed vector bench for id_regfile (bypass and no-bypass builds)
`timescale 1ns/1ps
module tb_id_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  ra, rb, rw, dbg_addr;
  logic [31:0] din;
  logic        we;
  logic [31:0] bus_a, bus_b, dbg_data, wr_count;
  logic [31:0] nb_bus_a, nb_bus_b, nb_dbg_data, nb_wr_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_regfile #(.BYPASS_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .IDin_Ra(ra), .IDin_Rb(rb), .WRin_RegDin(din),
    .WRin_Rw(rw), .WRin_RegWE(we), .IDout_BusA(bus_a), .IDout_BusB(bus_b),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .wr_count(wr_count)
  );

  id_regfile #(.BYPASS_EN(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .IDin_Ra(ra), .IDin_Rb(rb), .WRin_RegDin(din),
    .WRin_Rw(rw), .WRin_RegWE(we), .IDout_BusA(nb_bus_a), .IDout_BusB(nb_bus_b),
    .dbg_addr(dbg_addr), .dbg_data(nb_dbg_data), .wr_count(nb_wr_count)
  );

  typedef struct packed {
    logic        we;
    logic [4:0]  rw;
    logic [31:0] din;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [4:0]  dbg;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [31:0] exp_a_nb;
    logic [31:0] exp_dbg;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [4:0] waddr, input logic [31:0] wdata,
                       input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
    we = w; rw = waddr; din = wdata; ra = a; rb = b; dbg_addr = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //          we   rw     din           ra     rb     dbg    exp_a         exp_b         exp_a_nb      exp_dbg       exp_cnt
    vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  5'd5,  32'hDEADBEEF, 32'h0,        32'h0,        32'h0,        32'd0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'd1};
    vecs[2]  = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0,        32'd1};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0,        32'd1};
    vecs[4]  = '{1'b0, 5'd7,  32'hFFFF0000, 5'd7,  5'd7,  5'd7,  32'h0,        32'h0,        32'h0,        32'h0,        32'd1};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  5'd7,  32'h0,        32'h0,        32'h0,        32'h0,        32'd1};
    vecs[6]  = '{1'b1, 5'd3,  32'h1,        5'd3,  5'd3,  5'd3,  32'h1,        32'h1,        32'h0,        32'h0,        32'd1};
    vecs[7]  = '{1'b1, 5'd3,  32'h2,        5'd3,  5'd3,  5'd3,  32'h2,        32'h2,        32'h1,        32'h1,        32'd2};
    vecs[8]  = '{1'b1, 5'd3,  32'h3,        5'd3,  5'd3,  5'd3,  32'h3,        32'h3,        32'h2,        32'h2,        32'd3};
    vecs[9]  = '{1'b0, 5'd0,  32'h0,        5'd3,  5'd5,  5'd3,  32'h3,        32'hDEADBEEF, 32'h3,        32'h3,        32'd4};
    vecs[10] = '{1'b1, 5'd4,  32'h55,       5'd4,  5'd3,  5'd4,  32'h55,       32'h3,        32'h0,        32'h0,        32'd4};
    vecs[11] = '{1'b0, 5'd0,  32'h0,        5'd4,  5'd4,  5'd4,  32'h55,       32'h55,       32'h55,       32'h55,       32'd5};
    vecs[12] = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd1,  5'd31, 32'hCAFEF00D, 32'h0,        32'h0,        32'h0,        32'd5};
    vecs[13] = '{1'b0, 5'd31, 32'h0,        5'd31, 5'd31, 5'd31, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 32'd6};
    vecs[14] = '{1'b1, 5'd1,  32'h11111111, 5'd2,  5'd1,  5'd1,  32'h0,        32'h11111111, 32'h0,        32'h0,        32'd6};
    vecs[15] = '{1'b0, 5'd0,  32'h0,        5'd1,  5'd2,  5'd1,  32'h11111111, 32'h0,        32'h11111111, 32'h11111111, 32'd7};

    rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
    @(posedge clk); #1;
    chk("reset_bus_a", 0, bus_a, 32'h0);
    chk("reset_dbg", 0, dbg_data, 32'h0);
    chk("reset_cnt", 0, wr_count, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].we, vecs[i].rw, vecs[i].din, vecs[i].ra, vecs[i].rb, vecs[i].dbg);
      #2;
      chk("bus_a", i, bus_a, vecs[i].exp_a);
      chk("bus_b", i, bus_b, vecs[i].exp_b);
      chk("nb_bus_a", i, nb_bus_a, vecs[i].exp_a_nb);
      chk("dbg_data", i, dbg_data, vecs[i].exp_dbg);
      chk("wr_count", i, wr_count, vecs[i].exp_cnt);
      @(posedge clk); #1;
    end

    // Unknown write address with WE low must leave every entry alone
    drive(1'b0, 5'bxxxxx, 32'hBAD0BAD0, 5'd3, 5'd5, 5'd3);
    @(posedge clk); #1;
    chk("x_rw_r3", 0, dbg_data, 32'h3);
    chk("x_rw_r5", 0, bus_b, 32'hDEADBEEF);
    chk("x_rw_cnt", 0, wr_count, 32'd7);

    // Asynchronous reset in mid-cycle after loading r10
    drive(1'b1, 5'd10, 32'hA5A5A5A5, 5'd3, 5'd3, 5'd10);
    @(posedge clk); #1;
    drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd3, 5'd10);
    #1;
    chk("r10_loaded", 0, dbg_data, 32'hA5A5A5A5);
    chk("r10_cnt", 0, wr_count, 32'd8);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_dbg", 0, dbg_data, 32'h0);
    chk("async_rst_cnt", 0, wr_count, 32'h0);
    chk("async_rst_bus_a", 0, bus_a, 32'h0);

    // Write held across an edge while reset is low: reset wins
    drive(1'b1, 5'd6, 32'h66, 5'd6, 5'd0, 5'd6);
    #1;
    chk("rst_bypass_a", 0, bus_a, 32'h66);
    @(posedge clk); #1;
    chk("rst_win_dbg", 0, dbg_data, 32'h0);
    chk("rst_win_cnt", 0, wr_count, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("first_commit_dbg", 0, dbg_data, 32'h66);
    chk("first_commit_cnt", 0, wr_count, 32'd1);
    chk("first_commit_nb_cnt", 0, nb_wr_count, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
